// File: rtl/ser_flit_rx.sv
// Serial flit receiver: synchronizer, start/data/parity/stop framer, show-ahead FIFO; stop bit on the synced line -> flit_valid next cycle.
// Backpressure via the level not_full credit; a good frame reaching a full FIFO with no pop is dropped and sets sticky ovf_err.
module ser_flit_rx #(
    parameter int FLIT_W      = 32,
    parameter int DEPTH       = 4,
    parameter int AF_MARGIN   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ser_in,
    input  logic              EN_getFlit,
    output logic [FLIT_W-1:0] getFlit,
    output logic              flit_valid,
    output logic              not_full,
    output logic              frame_err,
    output logic [7:0]        par_err_cnt,
    output logic              ovf_err
);

    localparam int CNT_W = $clog2(FLIT_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FLIT_W-1:0]      r_shift;
    logic                   r_par_ok;
    logic                   r_frame_err;
    logic [7:0]             r_par_err_cnt;

    logic [FLIT_W-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_not_full;
    logic                   r_ovf;

    logic                   w_s;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovf;
    logic [CW-1:0]          w_count_next;
    logic [CW-1:0]          w_free;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_sync <= '1;
        end else begin
            r_sync[0] <= ser_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_ok      <= 1'b0;
            r_frame_err   <= 1'b0;
            r_par_err_cnt <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_s) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    r_shift[r_bit_cnt] <= w_s;
                    if (r_bit_cnt == CNT_W'(FLIT_W - 1)) begin
                        r_state <= S_PAR;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    r_par_ok <= (w_s == ^r_shift);
                    r_state  <= S_STOP;
                end
                S_STOP: begin
                    if (w_s) begin
                        if (!r_par_ok && (r_par_err_cnt != 8'hFF)) begin
                            r_par_err_cnt <= r_par_err_cnt + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // r_shift is stable through STOP: the next frame cannot enter DATA before IDLE.
    assign w_push  = (r_state == S_STOP) && w_s && r_par_ok;
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_pop   = EN_getFlit && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovf   = w_push && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    assign w_free = DEPTH_C - w_count_next;

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_not_full <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_not_full <= (w_free >= AF_C);
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign getFlit     = r_mem[r_rd_ptr];
    assign flit_valid  = !w_empty;
    assign not_full    = r_not_full;
    assign frame_err   = r_frame_err;
    assign par_err_cnt = r_par_err_cnt;
    assign ovf_err     = r_ovf;

endmodule

// File: tb/tb_ser_flit_rx.sv
// Directed bench for ser_flit_rx: framing, latency, FIFO fill/overflow, parity/frame errors, mid-frame reset.
module tb_ser_flit_rx;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        ser_in = 1'b1;
    logic        EN_getFlit = 1'b0;
    logic [31:0] getFlit;
    logic        flit_valid;
    logic        not_full;
    logic        frame_err;
    logic [7:0]  par_err_cnt;
    logic        ovf_err;

    int n_vec  = 0;
    int n_fail = 0;

    ser_flit_rx #(
        .FLIT_W     (32),
        .DEPTH      (4),
        .AF_MARGIN  (2),
        .SYNC_STAGES(2)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ser_in     (ser_in),
        .EN_getFlit (EN_getFlit),
        .getFlit    (getFlit),
        .flit_valid (flit_valid),
        .not_full   (not_full),
        .frame_err  (frame_err),
        .par_err_cnt(par_err_cnt),
        .ovf_err    (ovf_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        ser_in = 1'b1;
        tick(n);
    endtask

    // Leaves ser_in at the stop value so another frame can follow with no gap.
    task automatic send_frame(input logic [31:0] d, input logic p, input logic stop);
        ser_in = 1'b0;
        tick(1);
        for (int i = 0; i < 32; i++) begin
            ser_in = d[i];
            tick(1);
        end
        ser_in = p;
        tick(1);
        ser_in = stop;
        tick(1);
    endtask

    task automatic send_good(input logic [31:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk_b({tag, "_valid"}, flit_valid, 1'b1);
        chk_w(tag, getFlit, exp);
        EN_getFlit = 1'b1;
        tick(1);
        EN_getFlit = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_w({tag, "_getFlit"}, getFlit, 32'h0);
        chk_b({tag, "_flit_valid"}, flit_valid, 1'b0);
        chk_b({tag, "_not_full"}, not_full, 1'b1);
        chk_b({tag, "_frame_err"}, frame_err, 1'b0);
        chk_w({tag, "_par_err_cnt"}, 32'(par_err_cnt), 32'd0);
        chk_b({tag, "_ovf_err"}, ovf_err, 1'b0);
    endtask

    logic [31:0] v [4];
    logic [31:0] d_rst;
    int          pulses;
    int          seen_valid;

    initial begin
        v[0] = 32'h11111111;
        v[1] = 32'h22222222;
        v[2] = 32'h33333333;
        v[3] = 32'h44444444;

        // Power-on reset
        RST_N = 1'b1;
        tick(3);
        chk_reset_vals("por");
        RST_N = 1'b0;
        tick(2);

        // Single frame: flit appears exactly 37 edges after the start bit is driven
        send_frame(32'hDEADBEEF, 1'b0, 1'b1);
        idle(1);
        chk_b("single_not_yet", flit_valid, 1'b0);
        idle(1);
        chk_b("single_valid", flit_valid, 1'b1);
        chk_w("single_data", getFlit, 32'hDEADBEEF);
        chk_b("single_not_full", not_full, 1'b1);
        EN_getFlit = 1'b1;
        tick(1);
        EN_getFlit = 1'b0;
        chk_b("single_popped", flit_valid, 1'b0);

        // Back-to-back frames, credit drops at 3 entries
        send_frame(32'h00000001, 1'b1, 1'b1);
        send_frame(32'hFFFFFFFF, 1'b0, 1'b1);
        idle(2);
        chk_w("b2b_head", getFlit, 32'h00000001);
        chk_b("b2b_two_not_full", not_full, 1'b1);
        send_good(32'h12345678);
        idle(2);
        chk_b("b2b_three_not_full", not_full, 1'b0);
        pop_chk("b2b_pop0", 32'h00000001);
        chk_b("b2b_two_again_not_full", not_full, 1'b1);
        pop_chk("b2b_pop1", 32'hFFFFFFFF);
        pop_chk("b2b_pop2", 32'h12345678);
        chk_b("b2b_empty", flit_valid, 1'b0);

        // Overflow: fifth frame into a full FIFO is dropped
        for (int k = 0; k < 4; k++) send_good(v[k]);
        idle(2);
        chk_b("ovf_full_not_full", not_full, 1'b0);
        chk_b("ovf_before", ovf_err, 1'b0);
        send_good(32'h55555555);
        idle(2);
        chk_b("ovf_set", ovf_err, 1'b1);
        for (int k = 0; k < 4; k++) pop_chk("ovf_pop", v[k]);
        chk_b("ovf_drained", flit_valid, 1'b0);
        chk_b("ovf_sticky", ovf_err, 1'b1);
        chk_b("ovf_drained_not_full", not_full, 1'b1);

        // Reset clears the sticky flag
        RST_N = 1'b1;
        #1;
        chk_reset_vals("rst2");
        tick(1);
        RST_N = 1'b0;
        tick(1);

        // Full FIFO with a pop in the fifth frame's STOP cycle
        for (int k = 0; k < 4; k++) send_good(v[k]);
        send_good(32'h55555555);
        idle(1);
        EN_getFlit = 1'b1;
        idle(1);
        EN_getFlit = 1'b0;
        chk_b("simul_ovf", ovf_err, 1'b0);
        chk_b("simul_not_full", not_full, 1'b0);
        pop_chk("simul_pop1", v[1]);
        pop_chk("simul_pop2", v[2]);
        pop_chk("simul_pop3", v[3]);
        pop_chk("simul_pop4", 32'h55555555);
        chk_b("simul_empty", flit_valid, 1'b0);

        // Parity errors: 0x3 has even parity, so P=1 is wrong
        send_frame(32'h00000003, 1'b1, 1'b1);
        idle(2);
        chk_b("par_no_push", flit_valid, 1'b0);
        chk_w("par_cnt1", 32'(par_err_cnt), 32'd1);
        repeat (254) send_frame(32'h00000003, 1'b1, 1'b1);
        idle(2);
        chk_w("par_cnt255", 32'(par_err_cnt), 32'd255);
        send_frame(32'h00000003, 1'b1, 1'b1);
        idle(2);
        chk_w("par_sat", 32'(par_err_cnt), 32'd255);
        chk_b("par_sat_no_push", flit_valid, 1'b0);

        // Frame error then stuck-low line
        pulses     = 0;
        seen_valid = 0;
        send_frame(32'hA5A5A5A5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ser_in = 1'b0;
            tick(1);
            if (frame_err) pulses++;
            if (flit_valid) seen_valid++;
        end
        for (int i = 0; i < 3; i++) begin
            ser_in = 1'b1;
            tick(1);
            if (frame_err) pulses++;
            if (flit_valid) seen_valid++;
        end
        chk_w("ferr_pulses", 32'(pulses), 32'd1);
        chk_w("ferr_no_push", 32'(seen_valid), 32'd0);
        chk_w("ferr_par_cnt", 32'(par_err_cnt), 32'd255);
        send_good(32'h0BADF00D);
        idle(2);
        chk_b("ferr_recover_valid", flit_valid, 1'b1);
        chk_w("ferr_recover_data", getFlit, 32'h0BADF00D);

        // Reset asserted while data bit 10 is on the line
        d_rst = 32'hFFFFFC01;
        ser_in = 1'b0;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            ser_in = d_rst[i];
            tick(1);
        end
        ser_in = d_rst[10];
        RST_N  = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick(1);
        ser_in = d_rst[11];
        tick(1);
        ser_in = d_rst[12];
        RST_N  = 1'b0;
        tick(1);
        for (int i = 13; i < 32; i++) begin
            ser_in = d_rst[i];
            tick(1);
        end
        ser_in = ^d_rst;
        tick(1);
        ser_in = 1'b1;
        tick(1);
        idle(40);
        chk_b("midrst_no_push", flit_valid, 1'b0);
        chk_w("midrst_par_cnt", 32'(par_err_cnt), 32'd0);
        send_good(32'hCAFEF00D);
        idle(2);
        pop_chk("midrst_next", 32'hCAFEF00D);
        chk_b("midrst_empty", flit_valid, 1'b0);
        chk_b("midrst_ovf", ovf_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
